// File: rtl/biriscv_csr_sequencer.sv
// Serialises CSR/system ops from two issue slots into the CSR unit and holds
// the pipeline in BLOCK until flush completes or times out. Define CSR_SEQ_RR_EN for round-robin arbitration.
module biriscv_csr_sequencer #(
    parameter int unsigned BLOCK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    input  logic [31:0] req0_opcode_i,
    input  logic [31:0] req0_pc_i,
    input  logic [31:0] req0_ra_operand_i,

    input  logic        req1_valid_i,
    input  logic [31:0] req1_opcode_i,
    input  logic [31:0] req1_pc_i,
    input  logic [31:0] req1_ra_operand_i,

    output logic        req0_accept_o,
    output logic        req1_accept_o,

    output logic        csr_valid_o,
    output logic [31:0] csr_opcode_o,
    output logic [31:0] csr_pc_o,
    output logic [31:0] csr_ra_operand_o,
    input  logic [5:0]  csr_exception_i,

    input  logic        flush_done_i,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK,
        ST_BLOCK
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(BLOCK_TIMEOUT);

    state_t      state_q, state_d;
    logic        csr_valid_q, csr_valid_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [31:0] opcode_q, opcode_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ra_q, ra_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
`ifdef CSR_SEQ_RR_EN
    logic        rr_ptr_q, rr_ptr_d;
`endif

    logic        grant;
    logic        winner;

    // Accept is a same-cycle handshake; gating with rst_i keeps it quiet during reset.
    always_comb begin
        grant = ~rst_i && (state_q == ST_IDLE) && (req0_valid_i || req1_valid_i);
`ifdef CSR_SEQ_RR_EN
        if (req0_valid_i && req1_valid_i) begin
            winner = rr_ptr_q;
        end else begin
            winner = ~req0_valid_i;
        end
`else
        winner = ~req0_valid_i;
`endif
    end

    assign req0_accept_o = grant & ~winner;
    assign req1_accept_o = grant &  winner;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        pc_d       = pc_q;
        ra_d       = ra_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
`ifdef CSR_SEQ_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d  = ST_ISSUE;
                    opcode_d = winner ? req1_opcode_i     : req0_opcode_i;
                    pc_d     = winner ? req1_pc_i         : req0_pc_i;
                    ra_d     = winner ? req1_ra_operand_i : req0_ra_operand_i;
`ifdef CSR_SEQ_RR_EN
                    rr_ptr_d = ~winner;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = (csr_exception_i != '0) ? ST_BLOCK : ST_IDLE;
            end
            ST_BLOCK: begin
                // Flush completion outranks a timeout landing in the same cycle.
                if (flush_done_i) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        csr_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            csr_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            opcode_q    <= '0;
            pc_q        <= '0;
            ra_q        <= '0;
            wait_cnt_q  <= '0;
`ifdef CSR_SEQ_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            csr_valid_q <= csr_valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            opcode_q    <= opcode_d;
            pc_q        <= pc_d;
            ra_q        <= ra_d;
            wait_cnt_q  <= wait_cnt_d;
`ifdef CSR_SEQ_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign csr_valid_o      = csr_valid_q;
    assign csr_opcode_o     = opcode_q;
    assign csr_pc_o         = pc_q;
    assign csr_ra_operand_o = ra_q;
    assign busy_o           = busy_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_biriscv_csr_sequencer.sv
// Bench for biriscv_csr_sequencer: directed vector table, grant-order sequence
// and a randomized run against a timeline-based reference model.
module tb_biriscv_csr_sequencer;

    localparam int unsigned TB_T = 4;
`ifdef CSR_SEQ_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [5:0] EXC_ECALL   = 6'h0B;
    localparam logic [5:0] EXC_ERET    = 6'h10;
    localparam logic [5:0] EXC_ILLEGAL = 6'h02;
    localparam logic [5:0] EXC_FENCE   = 6'h20;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic [31:0] req0_opcode_i, req0_pc_i, req0_ra_operand_i;
    logic [31:0] req1_opcode_i, req1_pc_i, req1_ra_operand_i;
    logic        req0_accept_o, req1_accept_o;
    logic        csr_valid_o;
    logic [31:0] csr_opcode_o, csr_pc_o, csr_ra_operand_o;
    logic [5:0]  csr_exception_i;
    logic        flush_done_i;
    logic        busy_o, timeout_o;

    biriscv_csr_sequencer #(.BLOCK_TIMEOUT(TB_T)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req0_valid_i      (req0_valid_i),
        .req0_opcode_i     (req0_opcode_i),
        .req0_pc_i         (req0_pc_i),
        .req0_ra_operand_i (req0_ra_operand_i),
        .req1_valid_i      (req1_valid_i),
        .req1_opcode_i     (req1_opcode_i),
        .req1_pc_i         (req1_pc_i),
        .req1_ra_operand_i (req1_ra_operand_i),
        .req0_accept_o     (req0_accept_o),
        .req1_accept_o     (req1_accept_o),
        .csr_valid_o       (csr_valid_o),
        .csr_opcode_o      (csr_opcode_o),
        .csr_pc_o          (csr_pc_o),
        .csr_ra_operand_o  (csr_ra_operand_o),
        .csr_exception_i   (csr_exception_i),
        .flush_done_i      (flush_done_i),
        .busy_o            (busy_o),
        .timeout_o         (timeout_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: absolute cycle numbers of the current op's milestones.
    int          m_free   = 0;
    int          m_issue  = -1;
    int          m_check  = -1;
    int          m_bstart = -1;
    int          m_tout   = -1;
    logic [31:0] m_op = '0, m_pc = '0, m_ra = '0;
    bit          m_ptr = 1'b0;

    typedef struct {
        bit         rst, v0, v1;
        logic [5:0] exc;
        bit         flush, a0, a1, vld, busy, tmo;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit rst, bit v0, bit v1, logic [5:0] exc, bit flush,
                                bit a0, bit a1, bit vld, bit busy, bit tmo);
        vec_t r;
        r.rst = rst; r.v0 = v0; r.v1 = v1; r.exc = exc; r.flush = flush;
        r.a0 = a0; r.a1 = a1; r.vld = vld; r.busy = busy; r.tmo = tmo;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        bit idle, grant, win, e_a0, e_a1, e_v, e_b, e_t;
        idle  = (cyc >= m_free);
        grant = !rst_i && idle && (req0_valid_i || req1_valid_i);
        win   = (RR && req0_valid_i && req1_valid_i) ? m_ptr : !req0_valid_i;
        e_a0  = grant && !win;
        e_a1  = grant && win;
        e_v   = !rst_i && (cyc == m_issue);
        e_b   = !rst_i && !idle;
        e_t   = !rst_i && (cyc == m_tout);
        check("req0_accept", 32'(req0_accept_o), 32'(e_a0));
        check("req1_accept", 32'(req1_accept_o), 32'(e_a1));
        check("csr_valid",   32'(csr_valid_o),   32'(e_v));
        check("busy",        32'(busy_o),        32'(e_b));
        check("timeout",     32'(timeout_o),     32'(e_t));
        if (rst_i || e_b) begin
            check("csr_opcode", csr_opcode_o,     rst_i ? '0 : m_op);
            check("csr_pc",     csr_pc_o,         rst_i ? '0 : m_pc);
            check("csr_ra",     csr_ra_operand_o, rst_i ? '0 : m_ra);
        end
        if (rst_i) begin
            m_free = cyc + 1; m_issue = -1; m_check = -1; m_bstart = -1; m_tout = -1;
            m_op = '0; m_pc = '0; m_ra = '0; m_ptr = 1'b0;
        end else if (grant) begin
            m_issue = cyc + 1; m_check = cyc + 2; m_free = cyc + 3;
            m_bstart = -1; m_tout = -1;
            m_op  = win ? req1_opcode_i     : req0_opcode_i;
            m_pc  = win ? req1_pc_i         : req0_pc_i;
            m_ra  = win ? req1_ra_operand_i : req0_ra_operand_i;
            m_ptr = !win;
        end else if (cyc == m_check && csr_exception_i != '0) begin
            m_bstart = cyc + 1;
            m_free   = cyc + 2 + int'(TB_T);
            m_tout   = m_free;
        end else if (m_bstart >= 0 && cyc >= m_bstart && cyc < m_free && flush_done_i) begin
            m_free = cyc + 1;
            m_tout = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int  order[$];
    int  gcyc[$];
    int  exp_order[4];
    int  q0, q1;
    bit  have0, have1;

    initial begin
        rst_i = 1'b1; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        csr_exception_i = '0; flush_done_i = 1'b0;
        req0_opcode_i = 32'h3000_2073; req0_pc_i = 32'h8000_0100; req0_ra_operand_i = 32'h0000_1111;
        req1_opcode_i = 32'h0000_0073; req1_pc_i = 32'h8000_0204; req1_ra_operand_i = 32'h0000_2222;

        //   rst v0 v1 exc          fl  a0 a1 vld bsy tmo
        add(1, 0, 0, '0,          0,  0, 0, 0, 0, 0);
        add(0, 0, 0, '0,          1,  0, 0, 0, 0, 0);
        add(0, 1, 1, '0,          0,  1, 0, 0, 0, 0);
        add(0, 0, 1, '0,          0,  0, 0, 1, 1, 0);
        add(0, 0, 1, '0,          0,  0, 0, 0, 1, 0);
        add(0, 0, 1, '0,          0,  0, 1, 0, 0, 0);
        add(0, 0, 0, '0,          0,  0, 0, 1, 1, 0);
        add(0, 0, 0, '0,          1,  0, 0, 0, 1, 0);
        add(0, 1, 0, '0,          0,  1, 0, 0, 0, 0);
        add(0, 0, 0, '0,          0,  0, 0, 1, 1, 0);
        add(0, 0, 0, EXC_ECALL,   0,  0, 0, 0, 1, 0);
        add(0, 1, 0, '0,          0,  0, 0, 0, 1, 0);
        add(0, 1, 0, '0,          0,  0, 0, 0, 1, 0);
        add(0, 1, 0, '0,          1,  0, 0, 0, 1, 0);
        add(0, 1, 0, '0,          0,  1, 0, 0, 0, 0);
        add(0, 0, 0, '0,          0,  0, 0, 1, 1, 0);
        add(0, 0, 0, EXC_FENCE,   0,  0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, '0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, '0,          0,  0, 0, 0, 1, 0);
        add(0, 0, 0, '0,          0,  0, 0, 0, 0, 1);
        add(0, 0, 0, '0,          1,  0, 0, 0, 0, 0);
        add(0, 0, 1, '0,          0,  0, 1, 0, 0, 0);
        add(0, 0, 0, '0,          0,  0, 0, 1, 1, 0);
        add(0, 0, 0, EXC_ILLEGAL, 0,  0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, '0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, '0,          1,  0, 0, 0, 1, 0);
        add(0, 0, 0, '0,          0,  0, 0, 0, 0, 0);
        add(0, 1, 0, '0,          0,  1, 0, 0, 0, 0);
        add(0, 0, 0, '0,          0,  0, 0, 1, 1, 0);
        add(0, 0, 0, EXC_ERET,    0,  0, 0, 0, 1, 0);
        add(0, 0, 0, '0,          0,  0, 0, 0, 1, 0);
        add(1, 1, 0, '0,          0,  0, 0, 0, 0, 0);
        add(0, 1, 0, '0,          0,  1, 0, 0, 0, 0);
        add(0, 0, 0, '0,          0,  0, 0, 1, 1, 0);
        add(0, 0, 0, '0,          0,  0, 0, 0, 1, 0);
        add(0, 0, 0, '0,          0,  0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_i = vecs[i].rst; req0_valid_i = vecs[i].v0; req1_valid_i = vecs[i].v1;
            csr_exception_i = vecs[i].exc; flush_done_i = vecs[i].flush;
            #2;
            check("tbl_req0_accept", 32'(req0_accept_o), 32'(vecs[i].a0));
            check("tbl_req1_accept", 32'(req1_accept_o), 32'(vecs[i].a1));
            check("tbl_csr_valid",   32'(csr_valid_o),   32'(vecs[i].vld));
            check("tbl_busy",        32'(busy_o),        32'(vecs[i].busy));
            check("tbl_timeout",     32'(timeout_o),     32'(vecs[i].tmo));
            model_cycle();
            tick();
        end

        // Two ops queued in each slot, each requester advances on its accept.
        rst_i = 1'b1; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        csr_exception_i = '0; flush_done_i = 1'b0;
        #2; model_cycle(); tick();
        rst_i = 1'b0;
        q0 = 2; q1 = 2;
        if (RR) exp_order = '{0, 1, 0, 1};
        else    exp_order = '{0, 0, 1, 1};
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            req0_valid_i = (q0 > 0); req1_valid_i = (q1 > 0);
            #2;
            if (req0_accept_o) begin order.push_back(0); gcyc.push_back(cyc); q0--; end
            if (req1_accept_o) begin order.push_back(1); gcyc.push_back(cyc); q1--; end
            model_cycle();
            tick();
        end
        check("grant_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            check("grant_order", 32'(order[i]), 32'(exp_order[i]));
            if (i > 0) check("grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end

        // Randomized traffic against the model.
        have0 = 1'b0; have1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(99) == 0);
            if (!have0 && $urandom_range(2) == 0) begin
                have0 = 1'b1;
                req0_opcode_i = $urandom; req0_pc_i = $urandom; req0_ra_operand_i = $urandom;
            end
            if (!have1 && $urandom_range(2) == 0) begin
                have1 = 1'b1;
                req1_opcode_i = $urandom; req1_pc_i = $urandom; req1_ra_operand_i = $urandom;
            end
            req0_valid_i = have0 && ($urandom_range(7) != 0);
            req1_valid_i = have1 && ($urandom_range(7) != 0);
            csr_exception_i = ($urandom_range(2) == 0) ? 6'($urandom_range(63, 1)) : 6'd0;
            flush_done_i = ($urandom_range(5) == 0);
            #2;
            if (req0_accept_o) have0 = 1'b0;
            if (req1_accept_o) have1 = 1'b0;
            model_cycle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
